// File: rtl/alu_dispatch_if.sv
// Bundle between the dispatch stage, its upstream producer and the clocked ALU.
// Slave is the dispatch block; master is whatever drives instructions and returns results.
interface alu_dispatch_if #(
  parameter int TAGW = 3
) ();
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_opcode;
  logic [15:0]     in_op1;
  logic [15:0]     in_op2;
  logic [4:0]      in_immx;
  logic            in_isimm;
  logic [TAGW-1:0] in_tag;
  logic            stall;
  logic            flush;
  logic [11:0]     alusignals;
  logic [15:0]     op1;
  logic [15:0]     op2;
  logic [4:0]      immx;
  logic            isimmediate;
  logic [15:0]     aluresult;
  logic            wb_valid;
  logic [TAGW-1:0] wb_tag;
  logic [15:0]     wb_data;
  logic            err_illegal;

  modport slave (
    input  in_valid, in_opcode, in_op1, in_op2, in_immx, in_isimm, in_tag,
    input  stall, flush, aluresult,
    output in_ready, alusignals, op1, op2, immx, isimmediate,
    output wb_valid, wb_tag, wb_data, err_illegal
  );

  modport master (
    output in_valid, in_opcode, in_op1, in_op2, in_immx, in_isimm, in_tag,
    output stall, flush, aluresult,
    input  in_ready, alusignals, op1, op2, immx, isimmediate,
    input  wb_valid, wb_tag, wb_data, err_illegal
  );
endinterface

// File: rtl/alu_dispatch.sv
// Issue queue in front of a clocked ALU: decodes at enqueue, issues one entry per cycle
// and tracks the tag through the two-stage ALU pipeline for writeback.
module alu_dispatch #(
  parameter int DEPTH = 4,
  parameter int TAGW  = 3
) (
  input logic           clk,
  input logic           reset,
  alu_dispatch_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [11:0]     sig;
    logic [15:0]     op1;
    logic [15:0]     op2;
    logic [4:0]      immx;
    logic            isimm;
    logic [TAGW-1:0] tag;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic [11:0]     r_alusignals;
  logic [15:0]     r_op1;
  logic [15:0]     r_op2;
  logic [4:0]      r_immx;
  logic            r_isimm;
  logic            r_v1;
  logic [TAGW-1:0] r_tag1;
  logic            r_v2;
  logic [TAGW-1:0] r_wb_tag;
  logic            r_err;

  logic            w_full;
  logic            w_accept;
  logic            w_legal;
  logic            w_enq;
  logic            w_issue;
  logic [11:0]     w_sig;
  entry_t          w_new;
  entry_t          w_head;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_accept = bus.in_valid && !w_full;
  assign w_legal  = (bus.in_opcode < 4'd12);
  assign w_enq    = w_accept && w_legal && !bus.flush;
  assign w_issue  = (r_count != '0) && !bus.stall && !bus.flush;
  assign w_sig    = w_legal ? (12'(1) << bus.in_opcode) : 12'd0;
  assign w_head   = r_mem[r_rd_ptr];

  always_comb begin
    w_new       = '0;
    w_new.sig   = w_sig;
    w_new.op1   = bus.in_op1;
    w_new.op2   = bus.in_op2;
    w_new.immx  = bus.in_immx;
    w_new.isimm = bus.in_isimm;
    w_new.tag   = bus.in_tag;
  end

  // NOTE: queue storage has no reset; validity is carried entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (!reset && w_enq) r_mem[r_wr_ptr] <= w_new;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_alusignals <= '0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_immx       <= '0;
      r_isimm      <= 1'b0;
      r_v1         <= 1'b0;
      r_tag1       <= '0;
      r_v2         <= 1'b0;
      r_wb_tag     <= '0;
      r_err        <= 1'b0;
    end else if (bus.flush) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_alusignals <= '0;
      r_v1         <= 1'b0;
      r_v2         <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_err <= w_accept && !w_legal;
      if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_issue) begin
        r_rd_ptr     <= r_rd_ptr + PW'(1);
        r_alusignals <= w_head.sig;
        r_op1        <= w_head.op1;
        r_op2        <= w_head.op2;
        r_immx       <= w_head.immx;
        r_isimm      <= w_head.isimm;
        r_tag1       <= w_head.tag;
        r_v1         <= 1'b1;
      end else begin
        r_alusignals <= '0;
        r_v1         <= 1'b0;
      end
      // Second stage lines up with the ALU's own output register.
      r_v2 <= r_v1;
      if (r_v1) r_wb_tag <= r_tag1;
      case ({w_enq, w_issue})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = !w_full;
  assign bus.alusignals  = r_alusignals;
  assign bus.op1         = r_op1;
  assign bus.op2         = r_op2;
  assign bus.immx        = r_immx;
  assign bus.isimmediate = r_isimm;
  assign bus.wb_valid    = r_v2;
  assign bus.wb_tag      = r_wb_tag;
  assign bus.wb_data     = bus.aluresult;
  assign bus.err_illegal = r_err;
endmodule

// File: tb/tb_alu_dispatch.sv
// Scoreboard bench for alu_dispatch: a behavioural clocked ALU answers the issued
// controls, expected writebacks are queued at enqueue and retired on wb_valid.
module tb_alu_dispatch;
  localparam int TAGW = 3;

  typedef struct {
    logic [TAGW-1:0] tag;
    logic [15:0]     data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [15:0] r_alu;
  exp_t        sb[$];
  int          n_cmp;
  int          n_err;

  alu_dispatch_if #(.TAGW(TAGW)) bus ();

  alu_dispatch #(.DEPTH(4), .TAGW(TAGW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] alu_model(input logic [11:0] sig, input logic [15:0] a,
                                            input logic [15:0] op2, input logic [4:0] imm,
                                            input logic isimm);
    logic [15:0] b;
    logic [31:0] p;
    b = isimm ? {11'd0, imm} : op2;
    p = a * b;
    case (sig)
      12'h001, 12'h002, 12'h004: return a + b;
      12'h008: return a - b;
      12'h010: return p[15:0];
      12'h020: return (a < b) ? 16'd1 : 16'd0;
      12'h040: return b;
      12'h080: return a | b;
      12'h100: return a & b;
      12'h200: return ~a;
      12'h400: return a << b[3:0];
      12'h800: return a >> b[3:0];
      default: return 16'd0;
    endcase
  endfunction

  // Clocked ALU stand-in: result appears one edge after the controls are presented.
  always @(posedge clk) r_alu <= alu_model(bus.alusignals, bus.op1, bus.op2, bus.immx, bus.isimmediate);
  assign bus.aluresult = r_alu;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.wb_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("wb_unexpected", {29'd0, bus.wb_tag}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_tag", {29'd0, bus.wb_tag}, {29'd0, e.tag});
        check("wb_data", {16'd0, bus.wb_data}, {16'd0, e.data});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b,
                      input logic [4:0] imm, input logic isimm, input logic [TAGW-1:0] tag);
    int waited;
    exp_t e;
    bus.in_valid  = 1'b1;
    bus.in_opcode = opc;
    bus.in_op1    = a;
    bus.in_op2    = b;
    bus.in_immx   = imm;
    bus.in_isimm  = isimm;
    bus.in_tag    = tag;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) check("send_timeout", 32'd0, 32'd1);
    if (opc < 4'd12) begin
      e.tag  = tag;
      e.data = alu_model(12'(1) << opc, a, b, imm, isimm);
      sb.push_back(e);
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 50) begin
      tick();
      waited++;
    end
    check("drain_left", sb.size(), 32'd0);
    repeat (3) tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_op1 = '0; bus.in_op2 = '0;
    bus.in_immx = '0; bus.in_isimm = 1'b0; bus.in_tag = '0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_alusignals", {20'd0, bus.alusignals}, 32'd0);
    check("rst_op1", {16'd0, bus.op1}, 32'd0);
    check("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("rst_wb_tag", {29'd0, bus.wb_tag}, 32'd0);
    check("rst_err", {31'd0, bus.err_illegal}, 32'd0);

    // add: controls visible one edge after enqueue
    send(4'd0, 16'h0002, 16'h0003, 5'd0, 1'b0, 3'd5);
    check("add_pre_issue", {20'd0, bus.alusignals}, 32'd0);
    tick();
    check("add_alusignals", {20'd0, bus.alusignals}, 32'h001);
    check("add_op1", {16'd0, bus.op1}, 32'h0002);
    check("add_op2", {16'd0, bus.op2}, 32'h0003);
    tick();
    check("add_sig_cleared", {20'd0, bus.alusignals}, 32'd0);
    drain();

    // immediate mov
    send(4'd6, 16'h0000, 16'h1234, 5'd3, 1'b1, 3'd1);
    tick();
    check("mov_alusignals", {20'd0, bus.alusignals}, 32'h040);
    check("mov_isimm", {31'd0, bus.isimmediate}, 32'd1);
    check("mov_immx", {27'd0, bus.immx}, 32'd3);
    drain();

    // full queue under stall
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) send(4'(i + 3), 16'(100 + i), 16'(7 + i), 5'd0, 1'b0, 3'(i));
    check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    repeat (3) tick();
    check("stall_no_wb", {31'd0, bus.wb_valid}, 32'd0);
    check("stall_no_issue", {20'd0, bus.alusignals}, 32'd0);
    bus.stall = 1'b0;
    send(4'd10, 16'h0003, 16'h0004, 5'd0, 1'b0, 3'd4);
    drain();

    // illegal opcode
    send(4'd13, 16'h00AA, 16'h0055, 5'd0, 1'b0, 3'd2);
    check("ill_err_pulse", {31'd0, bus.err_illegal}, 32'd1);
    check("ill_alusignals", {20'd0, bus.alusignals}, 32'd0);
    tick();
    check("ill_err_cleared", {31'd0, bus.err_illegal}, 32'd0);
    check("ill_no_issue", {20'd0, bus.alusignals}, 32'd0);
    repeat (4) tick();

    // flush: 3 queued, 1 in flight, plus a simultaneous enqueue that must be dropped
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) send(4'd8, 16'h00F0, 16'(i + 1), 5'd0, 1'b0, 3'(i + 4));
    bus.stall = 1'b0;
    tick();
    check("flush_issued", {20'd0, bus.alusignals}, 32'h100);
    bus.flush = 1'b1;
    bus.in_valid = 1'b1; bus.in_opcode = 4'd0; bus.in_tag = 3'd0;
    @(posedge clk);
    sb.delete();
    #1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("flush_alusignals", {20'd0, bus.alusignals}, 32'd0);
    repeat (6) tick();
    send(4'd0, 16'd10, 16'd20, 5'd0, 1'b0, 3'd3);
    drain();

    // reset during back-to-back issues
    bus.stall = 1'b1;
    send(4'd7, 16'h0F00, 16'h00F0, 5'd0, 1'b0, 3'd1);
    send(4'd6, 16'h1111, 16'h0000, 5'd7, 1'b1, 3'd2);
    send(4'd3, 16'h0009, 16'h0004, 5'd0, 1'b0, 3'd3);
    bus.stall = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    @(posedge clk);
    sb.delete();
    #1;
    check("mid_rst_alusignals", {20'd0, bus.alusignals}, 32'd0);
    check("mid_rst_op1", {16'd0, bus.op1}, 32'd0);
    check("mid_rst_op2", {16'd0, bus.op2}, 32'd0);
    check("mid_rst_immx", {27'd0, bus.immx}, 32'd0);
    check("mid_rst_isimm", {31'd0, bus.isimmediate}, 32'd0);
    check("mid_rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    check("mid_rst_wb_tag", {29'd0, bus.wb_tag}, 32'd0);
    check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    reset = 1'b0;
    repeat (6) tick();
    check("end_sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_dispatch.md
ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 Parameter DEPTH, default 4, issue-queue entries; power of two, at least 2.
REQ-002 Parameter TAGW, default 3, width of the instruction tag.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  upstream has an instruction.
REQ-006 in_ready  output  1  queue can accept; equals !full.
REQ-007 in_opcode  input  4  ALU operation code.
REQ-008 in_op1 / in_op2  input  16 each  source operands.
REQ-009 in_immx  input  5  immediate field.
REQ-010 in_isimm  input  1  use the immediate instead of op2.
REQ-011 in_tag  input  TAGW  destination tag, returned with the result.
REQ-012 stall  input  1  inhibit issue.
REQ-013 flush  input  1  discard all queued and in-flight work.
REQ-014 alusignals  output  12  one-hot ALU control, registered.
REQ-015 op1 / op2  output  16 each  registered ALU operands.
REQ-016 immx  output  5  registered immediate.
REQ-017 isimmediate  output  1  registered immediate select.
REQ-018 aluresult  input  16  result from the clocked ALU.
REQ-019 wb_valid  output  1  one-cycle pulse; a result is present.
REQ-020 wb_tag  output  TAGW  tag of the result.
REQ-021 wb_data  output  16  result; equals aluresult while wb_valid is high, otherwise don't-care.
REQ-022 err_illegal  output  1  one-cycle pulse; an illegal opcode was dropped.

Function
REQ-023 Enqueue occurs on an edge where in_valid && in_ready; the entry stores opcode, op1, op2, immx, isimm and tag.
REQ-024 Decode at enqueue, opcode n (0..11) sets alusignals bit n: 0 add, 1 ld, 2 st, 3 sub, 4 mul, 5 cmp, 6 mov, 7 or, 8 and, 9 not, 10 lsl, 11 lsr.
REQ-025 Opcodes 12-15 are illegal: handshake is accepted, nothing is written to the queue, err_illegal pulses on the following cycle, and no wb_valid is ever produced for that instruction.
REQ-026 The queue is a FIFO with count 0..DEPTH; pointers wrap modulo DEPTH.
REQ-027 full = (count == DEPTH); an enqueue and a dequeue on the same edge leave count unchanged; there is no bypass into an empty queue.
REQ-028 Issue (dequeue) occurs on an edge where count > 0 && !stall && !flush; at most one issue per cycle, in FIFO order.
REQ-029 On an issue edge, alusignals/op1/op2/immx/isimmediate load the head entry; on any non-issue edge alusignals loads 0 and the other ALU outputs hold their values.
REQ-030 Latency: enqueue at edge E0 allows earliest issue at edge E1, so the ALU inputs are visible after E1.
REQ-031 An internal valid bit follows the issue pipeline, so wb_valid is high for exactly the cycle after E2, with wb_tag equal to the issued tag.
REQ-032 Back-to-back issues produce back-to-back wb_valid pulses; stall does not cancel an in-flight result.
REQ-033 flush on an edge: count goes to 0, pointers to 0, alusignals to 0, and both pipeline valid bits are cleared, so no wb_valid follows.
REQ-034 flush takes priority over a simultaneous enqueue, and that enqueue is dropped; in_ready stays !full.
REQ-035 Operand widths pass through unmodified; the block performs no arithmetic.

Reset
REQ-036 On a reset edge, values are: count 0, pointers 0, alusignals 0, op1 0, op2 0, immx 0, isimmediate 0, pipeline valids 0, wb_valid 0, wb_tag 0, err_illegal 0.
REQ-037 in_ready reads 1 in the cycle after reset.
REQ-038 Reset asserted mid-operation discards all queued and in-flight instructions, and no wb_valid is issued for them.
REQ-039 reset takes priority over flush, enqueue and issue.

Verification
REQ-040 add: opcode 0, op1 0x0002, op2 0x0003, tag 5 -> alusignals 0x001 after E1; wb_valid one cycle after E2 with wb_tag 5 and wb_data 0x0005.
REQ-041 Immediate mov: opcode 6, isimm 1, immx 3 -> alusignals 0x040, isimmediate 1, immx 3; wb_data 0x0003.
REQ-042 Full queue: stall held high, 5 instructions offered -> in_ready low after 4 accepts; release stall -> 4 pulses in order, then the 5th.
REQ-043 Illegal opcode 13, tag 2 -> err_illegal pulses once, alusignals stays 0, no wb_valid carries tag 2.
REQ-044 flush with 3 entries queued and 1 in flight -> no further wb_valid, in_ready 1, and the next enqueue issues normally.
REQ-045 reset during back-to-back issues -> all outputs at their reset values next cycle and no stale wb_valid.
